// File: rtl/ic_resp_pkg.sv
// ic_resp_pkg: shared types, default sizes and allocator helper for the response tracker.
package ic_resp_pkg;
  localparam int IC_MSTR_NUM  = 4;
  localparam int IC_MSTR_BITS = 2;
  localparam int IC_ID_BITS   = 4;
  localparam int IC_ENTRIES   = 8;
  localparam int IC_OUTS_BITS = 3;
  typedef struct packed {
    logic                    valid;
    logic [IC_ID_BITS-1:0]   id;
    logic [IC_MSTR_BITS-1:0] mstr;
    logic [IC_OUTS_BITS-1:0] cnt;
  } ic_resp_entry_t;
  // Lowest set bit of a free vector (up to 32 slots); caller checks for any-free separately.
  function automatic int unsigned find_first_free(input logic [31:0] v);
    int unsigned r;
    r = 0;
    for (int k = 31; k >= 0; k--) if (v[k]) r = 32'(k);
    return r;
  endfunction
endpackage

// File: rtl/ic_resp_entry.sv
// ic_resp_entry: one tracker slot holding {id, mstr, outstanding count}.
module ic_resp_entry
  import ic_resp_pkg::*;
#(
  parameter int ID_BITS   = IC_ID_BITS,
  parameter int MSTR_BITS = IC_MSTR_BITS,
  parameter int OUTS_BITS = IC_OUTS_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alloc,
  input  logic                 inc,
  input  logic                 dec,
  input  logic [ID_BITS-1:0]   new_id,
  input  logic [MSTR_BITS-1:0] new_mstr,
  input  logic [ID_BITS-1:0]   cmd_id,
  input  logic [ID_BITS-1:0]   rsp_id,
  output logic                 valid,
  output logic                 cmd_match,
  output logic                 rsp_match,
  output logic                 sat,
  output logic [MSTR_BITS-1:0] mstr
);
  logic [ID_BITS-1:0]   id;
  logic [OUTS_BITS-1:0] cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      id    <= '0;
      mstr  <= '0;
      cnt   <= '0;
    end else if (alloc) begin
      valid <= 1'b1;
      id    <= new_id;
      mstr  <= new_mstr;
      cnt   <= OUTS_BITS'(1);
    end else if (inc && !dec) begin
      cnt <= cnt + 1'b1;
    end else if (dec && !inc) begin
      cnt   <= cnt - 1'b1;
      valid <= cnt != OUTS_BITS'(1);
    end
  end
  assign cmd_match = valid && id == cmd_id;
  assign rsp_match = valid && id == rsp_id;
  assign sat       = &cnt;
endmodule

// File: rtl/ic_resp_tracker.sv
// ic_resp_tracker: per-slave CAM mapping response IDs back to issuing masters.
// Optional IC_DECERR_EN: decode-error commands load err_mstr and route missed responses there.
module ic_resp_tracker
  import ic_resp_pkg::*;
#(
  parameter int MSTR_NUM  = IC_MSTR_NUM,
  parameter int MSTR_BITS = IC_MSTR_BITS,
  parameter int ID_BITS   = IC_ID_BITS,
  parameter int ENTRIES   = IC_ENTRIES,
  parameter int OUTS_BITS = IC_OUTS_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ID_BITS-1:0]   cmd_id,
  input  logic [MSTR_BITS-1:0] cmd_mstr,
  input  logic                 cmd_decerr,
  input  logic                 rsp_valid,
  input  logic                 rsp_ready,
  input  logic                 rsp_last,
  input  logic [ID_BITS-1:0]   rsp_id,
  output logic [MSTR_BITS-1:0] rsp_mstr,
  output logic                 rsp_hit,
  output logic                 busy
);
  logic [ENTRIES-1:0]   valid, cmd_match, rsp_match, sat, alloc, inc, dec;
  logic [MSTR_BITS-1:0] e_mstr [ENTRIES];
  logic [MSTR_BITS-1:0] hit_mstr, rsp_sel, fallback;
  logic                 cmd_hit, hit_sat, pop, pop_same, is_dec, push, track;
  int unsigned          first_free;
  logic                 unused_cfg;
  assign unused_cfg = ^{cmd_decerr, MSTR_NUM[0]};
  for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
    ic_resp_entry #(.ID_BITS(ID_BITS), .MSTR_BITS(MSTR_BITS), .OUTS_BITS(OUTS_BITS)) u_entry (
      .clk(clk), .reset(reset), .alloc(alloc[i]), .inc(inc[i]), .dec(dec[i]),
      .new_id(cmd_id), .new_mstr(cmd_mstr), .cmd_id(cmd_id), .rsp_id(rsp_id),
      .valid(valid[i]), .cmd_match(cmd_match[i]), .rsp_match(rsp_match[i]),
      .sat(sat[i]), .mstr(e_mstr[i])
    );
    assign inc[i]   = track && cmd_match[i];
    assign alloc[i] = track && !cmd_hit && first_free == i;
    assign dec[i]   = pop && rsp_match[i];
  end
  // At most one entry matches a given ID, so OR-ing the masked fields is a one-hot mux.
  always_comb begin
    hit_mstr = '0;
    rsp_sel  = '0;
    hit_sat  = 1'b0;
    for (int k = 0; k < ENTRIES; k++) begin
      hit_mstr = hit_mstr | (cmd_match[k] ? e_mstr[k] : '0);
      rsp_sel  = rsp_sel | (rsp_match[k] ? e_mstr[k] : '0);
      hit_sat  = hit_sat | (cmd_match[k] & sat[k]);
    end
  end
`ifdef IC_DECERR_EN
  logic [MSTR_BITS-1:0] err_mstr;
  always_ff @(posedge clk) begin
    if (reset) err_mstr <= '0;
    else if (push && is_dec) err_mstr <= cmd_mstr;
  end
  assign is_dec   = cmd_decerr;
  assign fallback = err_mstr;
`else
  assign is_dec   = 1'b0;
  assign fallback = '0;
`endif
  assign first_free = find_first_free(32'(~valid));
  assign cmd_hit    = |cmd_match;
  assign rsp_hit    = |rsp_match;
  assign rsp_mstr   = rsp_hit ? rsp_sel : fallback;
  assign busy       = |valid;
  assign pop        = rsp_valid && rsp_ready && rsp_last && rsp_hit;
  assign pop_same   = pop && rsp_id == cmd_id;
  // A saturated entry may accept one more command only when it loses one in the same edge.
  assign cmd_ready  = is_dec || (cmd_hit ? hit_mstr == cmd_mstr && (!hit_sat || pop_same) : !(&valid));
  assign push       = cmd_valid && cmd_ready;
  assign track      = push && !is_dec;
endmodule
